uart_result_tx_q8_24: RTL and testbench
=======================================

# uart_result_tx_q8_24

Result-return UART transmitter for the 4-parallel Q8.24 systolic accelerator. It latches the 3×3 result matrix (nine 32-bit Q8.24 words) when the compute FSM finishes. It then serializes the matrix as 36 bytes of 8N1 UART on the accelerator's serial output line, using the same byte order and baud timing the accelerator's receiver expects for A/B operand loading. It sits between the systolic core's result register and the top-level `rx_out` pin.

## Interface
- `BAUD_TICKS`, 10: clock cycles per UART bit.
- `NUM_WORDS`, 9: result words per transfer.
- `WORD_W`, 32: bits per result word (Q8.24). Must be a multiple of 8.

- `clk_in`  input  1  system clock; all logic on rising edge.
- `rst_in`  input  1  one clock; reset is synchronous and active-high.
- `start_in`  input  1  load-and-send request, sampled while idle.
- `result_packed`  input  NUM_WORDS*WORD_W  result matrix; word w at bits [w*WORD_W +: WORD_W].
- `tx_out`  output  1  UART serial line, idle high; drives top-level `rx_out`.
- `busy_out`  output  1  high from the cycle after an accepted start until the transfer ends.
- `done_out`  output  1  one-cycle pulse when the final stop bit completes.
- `byte_strobe_out`  output  1  one-cycle pulse at the start of each frame's start bit.

## Operation
- Reset values: `tx_out`=1, `busy_out`=0, `done_out`=0, `byte_strobe_out`=0. Counters are cleared and the FSM is IDLE.
- FSM states: IDLE → START → DATA → STOP → (next byte ? START : FINISH) → IDLE.
- IDLE: when `start_in`=1, capture `result_packed` into an internal shadow register and clear byte index to 0. Move to START. Later changes on `result_packed` do not affect the transfer.
- Byte order: byte k = shadow[8k +: 8], k = 0..NUM_WORDS*WORD_W/8−1. This sends word 0 first, least-significant byte first.
- Bit order: LSB first.
- START: `tx_out`=0 for BAUD_TICKS cycles.
- DATA: 8 bits, each held for BAUD_TICKS cycles.
- STOP: `tx_out`=1 for BAUD_TICKS cycles.
- No idle gap between frames: the next start bit directly follows the stop bit.
- FINISH: `done_out`=1 and `busy_out`=0 for one cycle, then IDLE.
- `start_in` while busy, or during the FINISH cycle, is ignored. It is not queued.
- Reset asserted mid-frame: on the next edge, `tx_out`=1 and all outputs return to reset values. No partial frame resumes.

## Timing
- `start_in` high at edge N (IDLE): `busy_out`=1, `tx_out`=0 and `byte_strobe_out`=1 after edge N+1.
- Frame length: 10·BAUD_TICKS cycles (100 at default).
- Default transfer: 36 frames = 3600 cycles.
- `done_out` is asserted for the single cycle after the last stop bit's final tick. The earliest `start_in` that is accepted is the one in the cycle after `done_out`.
- Baud counter runs 0..BAUD_TICKS−1 and wraps; the bit advances on the wrap.
- Byte index wraps only via FINISH. It never exceeds the byte count minus 1.

## Configuration
- `RESULT_TX_CHECKSUM_EN` defined: one extra frame follows byte 35. Its payload is the XOR of all 36 payload bytes. The transfer is 37 frames, and `done_out` fires after the checksum stop bit.
- Macro undefined: exactly 36 frames, with no checksum logic present.

## Structure
- Shared package `uart_pkg`:
  - `BAUD_TICKS_DEFAULT` (10)
  - `RESULT_BYTES` (36)
  - frame-state enum `uart_tx_state_t` (IDLE, START, DATA, STOP, FINISH)
  - `uart_byte_t` (8-bit)
- Sub-module `uart_tx_byte`: single-frame 8N1 serializer with a `load`/`ready` handshake and its own baud counter.
- Top module: shadow register, byte index, checksum accumulator, and sequencing FSM feeding `uart_tx_byte`.

## Test plan
- Reset with `result_packed` = all ones, no start → `tx_out`=1, `busy_out`=0, `done_out`=0 for 200 cycles.
- Word w = 0x01000000·(w+1) (Q8.24 values 1.0..9.0), pulse start → bench UART receiver decodes 36 bytes.
  - Expected: 00 00 00 01 00 00 00 02 … 00 00 00 09.
  - Each bit lasts exactly 10 cycles.
  - `done_out` pulses once, 3601 cycles after start.
- Loopback: feed `tx_out` into the accelerator's receiver path with byte pattern 0x80+i → receiver reassembles an identical 288-bit vector.
- Start pulses at cycles 50 and 1500 of a transfer, and `result_packed` changed mid-transfer → both starts ignored, output matches the captured snapshot, only one `done_out`.
- Reset asserted during the DATA bit 3 of byte 10 → `tx_out`=1 after the next edge, `busy_out`=0. A new start then sends byte 0 correctly.
- With `RESULT_TX_CHECKSUM_EN` and bytes 0x00..0x23 → 37th byte = 0x00 (XOR of 0..35), `done_out` at cycle 3701.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, frame-state enum and byte type
package uart_pkg;
  localparam int BAUD_TICKS_DEFAULT = 10;
  localparam int RESULT_BYTES = 36;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, FINISH} uart_tx_state_t;
  typedef logic [7:0] uart_byte_t;
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: single-frame 8N1 serializer, load accepted when ready_o (idle or last stop tick)
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int BAUD_TICKS = BAUD_TICKS_DEFAULT
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       load_i,
  input  uart_byte_t data_i,
  output logic       ready_o,
  output logic       tx_o,
  output logic       strobe_o
);
  localparam int CW = $clog2(BAUD_TICKS + 1);
  uart_tx_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  uart_byte_t sh_q, sh_d;
  logic wrap;
  assign wrap = cnt_q == CW'(BAUD_TICKS - 1);
  assign ready_o = state_q == IDLE || (state_q == STOP && wrap);
  assign tx_o = state_q == START ? 1'b0 : state_q == DATA ? sh_q[0] : 1'b1;
  assign strobe_o = state_q == START && cnt_q == '0;
  // baud counter, bit sequencing and back-to-back reload on the final stop tick
  always_comb begin
    state_d = state_q;
    cnt_d = (wrap || state_q == IDLE) ? '0 : cnt_q + CW'(1);
    bit_d = bit_q;
    sh_d = sh_q;
    if (wrap)
      case (state_q)
        START: begin state_d = DATA; bit_d = 3'd0; end
        DATA: begin
          state_d = bit_q == 3'd7 ? STOP : DATA;
          bit_d = bit_q + 3'd1;
          sh_d = sh_q >> 1;
        end
        STOP: state_d = IDLE;
        default: ;
      endcase
    if (load_i && ready_o) begin
      state_d = START;
      cnt_d = '0;
      bit_d = 3'd0;
      sh_d = data_i;
    end
  end
  // frame state registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
    end
  end
endmodule

// File: rtl/uart_result_tx_q8_24.sv
// uart_result_tx_q8_24: latches the Q8.24 result matrix and streams it LSB-byte-first as 8N1; RESULT_TX_CHECKSUM_EN appends an XOR byte
module uart_result_tx_q8_24
  import uart_pkg::*;
#(
  parameter int BAUD_TICKS = BAUD_TICKS_DEFAULT,
  parameter int NUM_WORDS = 9,
  parameter int WORD_W = 32
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        start_in,
  input  logic [NUM_WORDS*WORD_W-1:0] result_packed,
  output logic                        tx_out,
  output logic                        busy_out,
  output logic                        done_out,
  output logic                        byte_strobe_out
);
  localparam int NB = NUM_WORDS * WORD_W / 8;
`ifdef RESULT_TX_CHECKSUM_EN
  localparam int NF = NB + 1;
`else
  localparam int NF = NB;
`endif
  localparam int IW = $clog2(NF);
  uart_tx_state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [NB*8-1:0] sh_q, sh_d;
  logic load, ready;
  uart_byte_t data;
`ifdef RESULT_TX_CHECKSUM_EN
  uart_byte_t chk_q, chk_d;
  logic is_chk;
  assign is_chk = state_q == DATA && idx_q == IW'(NB - 1);
  assign data = is_chk ? chk_q : sh_q[7:0];
`else
  assign data = sh_q[7:0];
`endif
  assign busy_out = state_q == START || state_q == DATA;
  assign done_out = state_q == FINISH;
  // sequencing: snapshot on start, feed one byte per frame, shift the snapshot as bytes leave
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    sh_d = sh_q;
    load = 1'b0;
    case (state_q)
      IDLE: if (start_in) begin
        state_d = START;
        idx_d = '0;
        sh_d = result_packed;
      end
      START: begin
        load = 1'b1;
        state_d = DATA;
      end
      DATA: if (ready) begin
        if (idx_q == IW'(NF - 1)) state_d = FINISH;
        else begin
          load = 1'b1;
          idx_d = idx_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) sh_d = sh_q >> 8;
`ifdef RESULT_TX_CHECKSUM_EN
    chk_d = state_q == IDLE ? '0 : (load && !is_chk) ? chk_q ^ sh_q[7:0] : chk_q;
`endif
  end
  // sequencer registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      idx_q <= '0;
      sh_q <= '0;
`ifdef RESULT_TX_CHECKSUM_EN
      chk_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      sh_q <= sh_d;
`ifdef RESULT_TX_CHECKSUM_EN
      chk_q <= chk_d;
`endif
    end
  end
  uart_tx_byte #(.BAUD_TICKS(BAUD_TICKS)) u_tx (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .load_i(load),
    .data_i(data),
    .ready_o(ready),
    .tx_o(tx_out),
    .strobe_o(byte_strobe_out)
  );
endmodule

// File: tb/tb_uart_result_tx_q8_24.sv
// tb_uart_result_tx_q8_24: table-driven frame checks plus reset/abort corner sequences
module tb_uart_result_tx_q8_24;
  localparam int BT = 10, NW = 9, WW = 32, NB = 36, DW = NW * WW;
`ifdef RESULT_TX_CHECKSUM_EN
  localparam int NF = 37;
`else
  localparam int NF = 36;
`endif
  typedef struct {
    logic [DW-1:0] d;
    bit dis;
    logic [7:0] e3;
    logic [7:0] e35;
  } vec_t;
  logic clk_in = 1'b0, rst_in = 1'b1, start_in = 1'b0;
  logic [DW-1:0] result_packed = '0;
  logic tx_out, busy_out, done_out, byte_strobe_out;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] rx [NF];
  vec_t v [4];
  always #5 clk_in = ~clk_in;
  uart_result_tx_q8_24 #(.BAUD_TICKS(BT), .NUM_WORDS(NW), .WORD_W(WW)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .start_in(start_in),
    .result_packed(result_packed),
    .tx_out(tx_out),
    .busy_out(busy_out),
    .done_out(done_out),
    .byte_strobe_out(byte_strobe_out)
  );
  task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  function automatic logic [99:0] wave(input logic [7:0] b);
    logic [99:0] w;
    for (int i = 0; i < 100; i++) begin
      int k;
      k = i / 10;
      w[i] = k == 0 ? 1'b0 : k == 9 ? 1'b1 : b[k-1];
    end
    return w;
  endfunction
  task automatic run_xfer(input logic [DW-1:0] d, input bit dis);
    logic [99:0] gw, gs;
    logic [7:0] eb, x;
    logic [DW-1:0] asm;
    int bad, c;
    x = '0;
    bad = 0;
    @(negedge clk_in);
    result_packed = d;
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    for (int f = 0; f < NF; f++) begin
      eb = f < NB ? d[8*f +: 8] : x;
      if (f < NB) x = x ^ eb;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk_in);
        gw[i] = tx_out;
        gs[i] = byte_strobe_out;
        if (!busy_out || done_out) bad++;
        if (i % 10 == 5 && i >= 15 && i <= 85) rx[f][i/10-1] = tx_out;
        c = f * 100 + i;
        if (dis) begin
          start_in = c == 50 || c == 1500;
          if (c == 700) result_packed = ~d;
        end
      end
      chk($sformatf("wave_frame%0d", f), DW'(gw), DW'(wave(eb)));
      chk($sformatf("strobe_frame%0d", f), DW'(gs), DW'(100'b1));
    end
    chk("busy_no_early_done", DW'(bad), '0);
    @(negedge clk_in);
    chk("finish_done_busy_tx", DW'({done_out, busy_out, tx_out}), DW'(3'b101));
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      if (done_out || busy_out || !tx_out) bad++;
    end
    chk("post_idle", DW'(bad), '0);
    for (int k = 0; k < NB; k++) asm[8*k +: 8] = rx[k];
    chk("loopback", asm, d);
`ifdef RESULT_TX_CHECKSUM_EN
    chk("checksum", DW'(rx[NB]), DW'(x));
`endif
  endtask
  initial begin
    logic [99:0] gw;
    int bad;
    for (int w = 0; w < NW; w++) v[0].d[w*WW +: WW] = 32'h01000000 * (w + 1);
    v[0].dis = 1'b0; v[0].e3 = 8'h01; v[0].e35 = 8'h09;
    for (int i = 0; i < NB; i++) v[1].d[8*i +: 8] = 8'h80 + 8'(i);
    v[1].dis = 1'b1; v[1].e3 = 8'h83; v[1].e35 = 8'hA3;
    for (int i = 0; i < NB; i++) v[2].d[8*i +: 8] = 8'(i);
    v[2].dis = 1'b0; v[2].e3 = 8'h03; v[2].e35 = 8'h23;
    for (int w = 0; w < NW; w++) v[3].d[w*WW +: WW] = 32'hA55AF00F;
    v[3].dis = 1'b1; v[3].e3 = 8'hA5; v[3].e35 = 8'hA5;
    result_packed = '1;
    repeat (3) @(negedge clk_in);
    chk("reset_state", DW'({tx_out, busy_out, done_out, byte_strobe_out}), DW'(4'b1000));
    rst_in = 1'b0;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_in);
      if (!tx_out || busy_out || done_out || byte_strobe_out) bad++;
    end
    chk("idle_200", DW'(bad), '0);
    for (int t = 0; t < 4; t++) begin
      run_xfer(v[t].d, v[t].dis);
      chk($sformatf("vec%0d_byte3", t), DW'(rx[3]), DW'(v[t].e3));
      chk($sformatf("vec%0d_byte35", t), DW'(rx[35]), DW'(v[t].e35));
`ifdef RESULT_TX_CHECKSUM_EN
      if (t == 2) chk("checksum_0_to_35", DW'(rx[NB]), '0);
`endif
    end
    @(negedge clk_in);
    result_packed = v[0].d;
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    repeat (1046) @(negedge clk_in);
    chk("abort_mid_frame", DW'({busy_out, tx_out}), DW'(2'b10));
    rst_in = 1'b1;
    @(negedge clk_in);
    chk("abort_reset", DW'({tx_out, busy_out, done_out, byte_strobe_out}), DW'(4'b1000));
    rst_in = 1'b0;
    @(negedge clk_in);
    result_packed = v[1].d;
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_in);
      gw[i] = tx_out;
    end
    chk("restart_byte0", DW'(gw), DW'(wave(8'h80)));
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
